// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes, mux/ALU codes.
package mips_ctrl_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 6;

    localparam logic [3:0] S_RESET     = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_MEM_ADDR  = 4'd3;
    localparam logic [3:0] S_MEM_READ  = 4'd4;
    localparam logic [3:0] S_MEM_WB    = 4'd5;
    localparam logic [3:0] S_MEM_WRITE = 4'd6;
    localparam logic [3:0] S_EXEC      = 4'd7;
    localparam logic [3:0] S_R_WB      = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JUMP      = 4'd10;
    localparam logic [3:0] S_ADDI_EXEC = 4'd11;
    localparam logic [3:0] S_ADDI_WB   = 4'd12;
    localparam logic [3:0] S_ILLEGAL   = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    // Dispatch target out of S_DECODE for a given opcode.
    function automatic logic [STATE_W-1:0] decode_target(input logic [OPCODE_W-1:0] op,
                                                         input logic trap);
        case (op)
            OP_RTYPE:      decode_target = S_EXEC;
            OP_LW, OP_SW:  decode_target = S_MEM_ADDR;
            OP_BEQ:        decode_target = S_BRANCH;
            OP_J:          decode_target = S_JUMP;
            OP_ADDI:       decode_target = S_ADDI_EXEC;
            default:       decode_target = trap ? S_ILLEGAL : S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: state register plus a combinational Moore decoder
// (only fetch ir/pc writes and instr_done are qualified by mem_ready).
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                mem_ready_i,
    output logic                pc_write_o,
    output logic                pc_write_cond_o,
    output logic                i_or_d_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                ir_write_o,
    output logic                reg_dst_o,
    output logic                mem_to_reg_o,
    output logic                reg_write_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [1:0]          alu_op_o,
    output logic [1:0]          pc_source_o,
    output logic                instr_done_o,
    output logic                illegal_op_o
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    ctrl_t              ctrl;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs decode from the current state so reset clears them without waiting for a clock.
    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready_i;
                ctrl.pc_write  = mem_ready_i;
                if (mem_ready_i) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
                state_d        = decode_target(opcode_i, ILLEGAL_TRAP);
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                state_d        = (opcode_i == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (mem_ready_i) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready_i;
                if (mem_ready_i) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
                state_d        = S_R_WB;
            end
            S_R_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
                state_d            = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                state_d        = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_ILLEGAL: begin
                ctrl.illegal_op = 1'b1;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    assign pc_write_o      = ctrl.pc_write;
    assign pc_write_cond_o = ctrl.pc_write_cond;
    assign i_or_d_o        = ctrl.i_or_d;
    assign mem_read_o      = ctrl.mem_read;
    assign mem_write_o     = ctrl.mem_write;
    assign ir_write_o      = ctrl.ir_write;
    assign reg_dst_o       = ctrl.reg_dst;
    assign mem_to_reg_o    = ctrl.mem_to_reg;
    assign reg_write_o     = ctrl.reg_write;
    assign alu_src_a_o     = ctrl.alu_src_a;
    assign alu_src_b_o     = ctrl.alu_src_b;
    assign alu_op_o        = ctrl.alu_op;
    assign pc_source_o     = ctrl.pc_source;
    assign instr_done_o    = ctrl.instr_done;
    assign illegal_op_o    = ctrl.illegal_op;

endmodule
